gumnut_port_timer: RTL and testbench

- Port-bus responder (the target side of the Gumnut I/O port bus) implementing an 8-bit programmable down-counter timer with an interrupt request line.
- Decodes a 4-register window at BASE_ADR, answers port_cyc/stb with a registered ack, and drives int_req toward the CPU.
- Retires int_req on the CPU's int_ack pulse.
- Sits beside data memory on the SoC top; first interrupt source for the core.

---
 rtl/gumnut_port_pkg.sv | 19 +
 rtl/gumnut_prescaler.sv | 40 ++++
 rtl/gumnut_port_timer.sv | 185 ++++++++++++++++++
 tb/tb_gumnut_port_timer.sv | 459 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gumnut_port_pkg.sv
// gumnut_port_pkg: shared constants for Gumnut I/O port peripherals.
//   REG_*  : register offsets within a 4-register port window (adr[1:0]).
//   CTRL_* : bit positions in the timer CTRL register.
//   STAT_* : bit positions in the timer STATUS register.
package gumnut_port_pkg;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_RELOAD = 2'd1;
  localparam logic [1:0] REG_COUNT  = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  localparam int unsigned CTRL_EN   = 0;
  localparam int unsigned CTRL_AUTO = 1;
  localparam int unsigned CTRL_IE   = 2;

  localparam int unsigned STAT_EXPIRED = 0;
  localparam int unsigned STAT_IRQ     = 1;

endpackage

// File: rtl/gumnut_prescaler.sv
// gumnut_prescaler: divides clk_i into a one-cycle tick every PRESCALE cycles.
//   clk_i : clock
//   rst_i : asynchronous active-high reset
//   en    : count enable; counter held at 0 while low
//   clr   : restart the count from 0 on this edge
//   tick  : high during the last cycle of each PRESCALE-cycle period
// PRESCALE legal range is 1..256.
module gumnut_prescaler #(
  parameter int unsigned PRESCALE = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CntW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(PRESCALE - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign tick = en & (cnt_q == CntMax);

  always_comb begin
    cnt_d = cnt_q + CntW'(1);
    if (!en || clr || tick) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/gumnut_port_timer.sv
// gumnut_port_timer: Gumnut port-bus target with an 8-bit down-counting timer and IRQ.
//   clk_i, rst_i          : clock, asynchronous active-high reset
//   port_cyc_i/stb_i/we_i : bus cycle, strobe, write enable from the CPU
//   port_adr_i/dat_i      : port address and write data
//   port_dat_o/ack_o      : read data (0 unless acked) and transfer acknowledge
//   int_req / int_ack     : level interrupt request, one-cycle acknowledge from CPU
// Registers (adr[1:0]): 0 CTRL {IE,AUTO,EN}, 1 RELOAD, 2 COUNT, 3 STATUS {IRQ,EXPIRED}.
// Build option: define GUMNUT_PORT_TIMER_ZERO_WAIT_EN for a combinational (zero-wait)
// ack and read data; otherwise the ack is registered with one wait state.
module gumnut_port_timer
  import gumnut_port_pkg::*;
#(
  parameter logic [7:0]  BASE_ADR = 8'h10,
  parameter int unsigned PRESCALE = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       port_cyc_i,
  input  logic       port_stb_i,
  input  logic       port_we_i,
  input  logic [7:0] port_adr_i,
  input  logic [7:0] port_dat_i,
  output logic [7:0] port_dat_o,
  output logic       port_ack_o,
  output logic       int_req,
  input  logic       int_ack
);

  logic       req, hit, xfer, wr_commit;
  logic [1:0] off;
  logic [7:0] rdata;

  logic       ctrl_en_q, ctrl_en_d;
  logic       ctrl_auto_q, ctrl_auto_d;
  logic       ctrl_ie_q, ctrl_ie_d;
  logic [7:0] reload_q, reload_d;
  logic [7:0] count_q, count_d;
  logic       expired_q, expired_d;

  logic tick, tick_eff, pre_clr;

  assign req = port_cyc_i & port_stb_i;
  assign hit = (port_adr_i[7:2] == BASE_ADR[7:2]);
  assign off = port_adr_i[1:0];

  // --------------------------------------------------------------------------
  // Bus handshake
  // --------------------------------------------------------------------------
`ifdef GUMNUT_PORT_TIMER_ZERO_WAIT_EN
  assign xfer       = req & hit;
  assign port_ack_o = xfer;
  assign port_dat_o = (xfer & ~port_we_i) ? rdata : 8'h00;
`else
  logic       ack_q;
  logic       done_q;
  logic [7:0] dat_q;

  // done_q remembers that the current strobe was already served, so a CPU
  // holding stb in its wait state gets a single ack per strobe.
  assign xfer = req & hit & ~done_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ack_q  <= 1'b0;
      done_q <= 1'b0;
      dat_q  <= 8'h00;
    end else begin
      ack_q  <= xfer;
      done_q <= req & (done_q | xfer);
      dat_q  <= (xfer & ~port_we_i) ? rdata : 8'h00;
    end
  end

  assign port_ack_o = ack_q;
  assign port_dat_o = dat_q;
`endif

  // Writes commit on the edge that raises (registered) or ends (zero-wait) the ack.
  assign wr_commit = xfer & port_we_i;

  // --------------------------------------------------------------------------
  // Prescaler
  // --------------------------------------------------------------------------
  // A CTRL write clearing EN restarts the prescaler and swallows a same-edge tick.
  assign pre_clr  = wr_commit & (off == REG_CTRL) & ~port_dat_i[CTRL_EN];
  assign tick_eff = tick & ~pre_clr;

  gumnut_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .en    (ctrl_en_q),
    .clr   (pre_clr),
    .tick  (tick)
  );

  assign int_req = expired_q & ctrl_ie_q;

  // --------------------------------------------------------------------------
  // Read mux
  // --------------------------------------------------------------------------
  always_comb begin
    rdata = 8'h00;
    case (off)
      REG_CTRL: begin
        rdata[CTRL_EN]   = ctrl_en_q;
        rdata[CTRL_AUTO] = ctrl_auto_q;
        rdata[CTRL_IE]   = ctrl_ie_q;
      end
      REG_RELOAD: rdata = reload_q;
      REG_COUNT:  rdata = count_q;
      REG_STATUS: begin
        rdata[STAT_EXPIRED] = expired_q;
        rdata[STAT_IRQ]     = int_req;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Timer and register next state
  // --------------------------------------------------------------------------
  always_comb begin
    ctrl_en_d   = ctrl_en_q;
    ctrl_auto_d = ctrl_auto_q;
    ctrl_ie_d   = ctrl_ie_q;
    reload_d    = reload_q;
    count_d     = count_q;
    expired_d   = expired_q;

    // Clears are applied first so that a same-edge expiry overrides them.
    if (int_ack && int_req) begin
      expired_d = 1'b0;
    end
    if (wr_commit && (off == REG_STATUS) && port_dat_i[STAT_EXPIRED]) begin
      expired_d = 1'b0;
    end

    if (tick_eff) begin
      if (count_q != 8'd0) begin
        count_d = count_q - 8'd1;
      end else begin
        expired_d = 1'b1;
        if (ctrl_auto_q) begin
          count_d = reload_q;
        end else begin
          ctrl_en_d = 1'b0;
        end
      end
    end

    // Bus writes override the timer's own updates on the same edge.
    if (wr_commit) begin
      case (off)
        REG_CTRL: begin
          ctrl_en_d   = port_dat_i[CTRL_EN];
          ctrl_auto_d = port_dat_i[CTRL_AUTO];
          ctrl_ie_d   = port_dat_i[CTRL_IE];
        end
        REG_RELOAD: reload_d = port_dat_i;
        REG_COUNT:  count_d  = port_dat_i;
        REG_STATUS: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ctrl_en_q   <= 1'b0;
      ctrl_auto_q <= 1'b0;
      ctrl_ie_q   <= 1'b0;
      reload_q    <= 8'h00;
      count_q     <= 8'h00;
      expired_q   <= 1'b0;
    end else begin
      ctrl_en_q   <= ctrl_en_d;
      ctrl_auto_q <= ctrl_auto_d;
      ctrl_ie_q   <= ctrl_ie_d;
      reload_q    <= reload_d;
      count_q     <= count_d;
      expired_q   <= expired_d;
    end
  end

endmodule

// File: tb/tb_gumnut_port_timer.sv
// tb_gumnut_port_timer: self-checking bench for gumnut_port_timer with a behavioural
// reference model. Honours GUMNUT_PORT_TIMER_ZERO_WAIT_EN for ack timing expectations.
module tb_gumnut_port_timer;
  import gumnut_port_pkg::*;

  localparam logic [7:0] BASE     = 8'h10;
  localparam int         PRESCALE = 4;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       port_cyc, port_stb, port_we;
  logic [7:0] port_adr, port_dat_w, port_dat_r;
  logic       port_ack, int_req, int_ack;

  int checks = 0;
  int failures = 0;
  int cyc_n = 0;
  int last_commit = 0;

  // Reference model state
  bit       m_en, m_auto, m_ie, m_exp;
  bit [7:0] m_reload, m_count;
  int       m_ps;  // edges elapsed since the timer was (re)enabled

  gumnut_port_timer #(
    .BASE_ADR (BASE),
    .PRESCALE (PRESCALE)
  ) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .port_cyc_i (port_cyc),
    .port_stb_i (port_stb),
    .port_we_i  (port_we),
    .port_adr_i (port_adr),
    .port_dat_i (port_dat_w),
    .port_dat_o (port_dat_r),
    .port_ack_o (port_ack),
    .int_req    (int_req),
    .int_ack    (int_ack)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    m_en = 0; m_auto = 0; m_ie = 0; m_exp = 0;
    m_reload = 0; m_count = 0; m_ps = 0;
  endtask

  function automatic bit [7:0] model_read(input logic [1:0] off);
    bit [7:0] r;
    r = 8'h00;
    case (off)
      REG_CTRL: begin
        r[CTRL_EN] = m_en; r[CTRL_AUTO] = m_auto; r[CTRL_IE] = m_ie;
      end
      REG_RELOAD: r = m_reload;
      REG_COUNT:  r = m_count;
      REG_STATUS: begin
        r[STAT_EXPIRED] = m_exp; r[STAT_IRQ] = m_exp & m_ie;
      end
    endcase
    return r;
  endfunction

  // One clock edge: the model advances using the inputs present at the edge.
  // commit = this edge is the one on which the current bus access takes effect.
  task automatic step(input bit commit);
    bit       wr, tick, en_clr;
    bit [1:0] off;
    bit [7:0] wd;
    bit       n_en, n_auto, n_ie, n_exp;
    bit [7:0] n_reload, n_count;
    @(posedge clk_i);
    wr     = commit && port_we;
    off    = port_adr[1:0];
    wd     = port_dat_w;
    en_clr = wr && (off == REG_CTRL) && !wd[CTRL_EN];
    tick   = m_en && (((m_ps + 1) % PRESCALE) == 0) && !en_clr;
    n_en = m_en; n_auto = m_auto; n_ie = m_ie; n_exp = m_exp;
    n_reload = m_reload; n_count = m_count;
    if (int_ack && m_exp && m_ie) n_exp = 0;
    if (wr && off == REG_STATUS && wd[STAT_EXPIRED]) n_exp = 0;
    if (tick) begin
      if (m_count == 0) begin
        n_exp = 1;
        if (m_auto) n_count = m_reload;
        else n_en = 0;
      end else begin
        n_count = m_count - 1;
      end
    end
    if (wr) begin
      if (off == REG_CTRL) begin
        n_en = wd[CTRL_EN]; n_auto = wd[CTRL_AUTO]; n_ie = wd[CTRL_IE];
      end
      if (off == REG_RELOAD) n_reload = wd;
      if (off == REG_COUNT) n_count = wd;
    end
    m_ps = (m_en && !en_clr) ? m_ps + 1 : 0;
    m_en = n_en; m_auto = n_auto; m_ie = n_ie; m_exp = n_exp;
    m_reload = n_reload; m_count = n_count;
    cyc_n++;
    if (commit) last_commit = cyc_n;
    @(negedge clk_i);
  endtask

  // One bus access. Returns the read data seen with the ack and whether the ack
  // had the expected shape (one cycle long, correct cycle, none on a miss).
  task automatic bus_xfer(input bit we, input logic [7:0] adr, input logic [7:0] wd,
                          output logic [7:0] rd, output bit ack_ok);
    bit hit;
    hit = (adr[7:2] == BASE[7:2]);
    port_cyc = 1; port_stb = 1; port_we = we; port_adr = adr; port_dat_w = wd;
    ack_ok = 1;
`ifdef GUMNUT_PORT_TIMER_ZERO_WAIT_EN
    #1;
    rd = port_dat_r;
    if (port_ack !== hit) ack_ok = 0;
    step(hit);
    port_cyc = 0; port_stb = 0;
    #1;
    if (port_ack !== 1'b0) ack_ok = 0;
`else
    #1;
    if (port_ack !== 1'b0) ack_ok = 0;
    step(hit);
    rd = port_dat_r;
    if (port_ack !== hit) ack_ok = 0;
    port_cyc = 0; port_stb = 0;
    step(0);
    if (port_ack !== 1'b0 || port_dat_r !== 8'h00) ack_ok = 0;
`endif
  endtask

  task automatic wr_reg(input logic [1:0] off, input logic [7:0] d);
    logic [7:0] rd;
    bit ok;
    bus_xfer(1, BASE | {6'd0, off}, d, rd, ok);
  endtask

  task automatic rd_reg(input logic [1:0] off, output logic [7:0] rd, output bit ok);
    bus_xfer(0, BASE | {6'd0, off}, $urandom, rd, ok);
  endtask

  // Steps until int_req is high (or the limit expires: rise = -1).
  task automatic wait_irq(input int limit, output int rise);
    rise = -1;
    for (int i = 0; i < limit && rise < 0; i++) begin
      if (int_req === 1'b1) rise = cyc_n;
      else step(0);
    end
  endtask

  task automatic test_reset();
    logic [7:0] rd;
    bit ok;
    port_cyc = 0; port_stb = 0; port_we = 0; port_adr = 0; port_dat_w = 0; int_ack = 0;
    rst_i = 0;
    #1 rst_i = 1;
    model_reset();
    repeat (2) @(negedge clk_i);
    checks++;
    if (port_ack !== 1'b0 || port_dat_r !== 8'h00 || int_req !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs: ack=%b dat=%h irq=%b, want 0/00/0", port_ack, port_dat_r,
               int_req);
    end
    rst_i = 0;
    for (int i = 0; i < 4; i++) begin
      rd_reg(i[1:0], rd, ok);
      checks++;
      if (rd !== 8'h00 || !ok) begin
        failures++;
        $display("FAIL reset_reg%0d: got %h ack_ok=%0d, want 00 ack_ok=1", i, rd, ok);
      end
    end
  endtask

  task automatic test_readback();
    logic [7:0] rd;
    bit ok;
    bus_xfer(1, BASE + 8'd1, 8'h5A, rd, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL write_ack_shape: ack_ok=0, want 1");
    end
    rd_reg(REG_RELOAD, rd, ok);
    checks++;
    if (rd !== 8'h5A || !ok) begin
      failures++;
      $display("FAIL reload_readback: got %h ack_ok=%0d, want 5a ack_ok=1", rd, ok);
    end
  endtask

  task automatic test_decode();
    logic [7:0] rd, exp_ctrl;
    bit ok;
    bus_xfer(0, BASE + 8'd4, 8'h00, rd, ok);
    checks++;
    if (rd !== 8'h00 || !ok) begin
      failures++;
      $display("FAIL miss_read: got %h ack_ok=%0d, want 00 no ack", rd, ok);
    end
    bus_xfer(1, BASE + 8'd4, 8'hFF, rd, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL miss_write: ack_ok=0, want no ack");
    end
    exp_ctrl = model_read(REG_CTRL);
    rd_reg(REG_CTRL, rd, ok);
    checks++;
    if (rd !== exp_ctrl) begin
      failures++;
      $display("FAIL miss_no_effect: ctrl got %h, want %h", rd, exp_ctrl);
    end
  endtask

  task automatic test_stall();
    int acks, want;
    port_cyc = 1; port_stb = 1; port_we = 0; port_adr = BASE + 8'd1; port_dat_w = 0;
    acks = 0;
    for (int i = 0; i < 3; i++) begin
`ifdef GUMNUT_PORT_TIMER_ZERO_WAIT_EN
      #1 if (port_ack === 1'b1) acks++;
`endif
      step(i == 0);
`ifndef GUMNUT_PORT_TIMER_ZERO_WAIT_EN
      if (port_ack === 1'b1) acks++;
`endif
    end
    port_cyc = 0; port_stb = 0;
    step(0);
    if (port_ack === 1'b1) acks++;
`ifdef GUMNUT_PORT_TIMER_ZERO_WAIT_EN
    want = 3;
`else
    want = 1;
`endif
    checks++;
    if (acks != want) begin
      failures++;
      $display("FAIL held_stb_acks: got %0d ack cycles, want %0d", acks, want);
    end
  endtask

  task automatic test_oneshot();
    logic [7:0] rd;
    bit ok;
    int t0, rise;
    wr_reg(REG_CTRL, 8'h00);
    wr_reg(REG_STATUS, 8'h01);
    wr_reg(REG_COUNT, 8'h02);
    wr_reg(REG_CTRL, 8'h05);
    t0 = last_commit;
    wait_irq(60, rise);
    checks++;
    if (rise < 0 || rise - t0 != 12) begin
      failures++;
      $display("FAIL oneshot_latency: got %0d cycles, want 12", rise < 0 ? -1 : rise - t0);
    end
    rd_reg(REG_CTRL, rd, ok);
    checks++;
    if (rd !== 8'h04) begin
      failures++;
      $display("FAIL oneshot_ctrl: got %h, want 04", rd);
    end
    rd_reg(REG_COUNT, rd, ok);
    checks++;
    if (rd !== 8'h00) begin
      failures++;
      $display("FAIL oneshot_count: got %h, want 00", rd);
    end
    rd_reg(REG_STATUS, rd, ok);
    checks++;
    if (rd !== 8'h03) begin
      failures++;
      $display("FAIL oneshot_status: got %h, want 03", rd);
    end
    int_ack = 1;
    step(0);
    int_ack = 0;
    checks++;
    if (int_req !== 1'b0) begin
      failures++;
      $display("FAIL oneshot_int_ack: int_req=%b, want 0", int_req);
    end
  endtask

  task automatic test_autoreload();
    int r0, r1;
    wr_reg(REG_CTRL, 8'h00);
    wr_reg(REG_STATUS, 8'h01);
    wr_reg(REG_RELOAD, 8'h03);
    wr_reg(REG_CTRL, 8'h07);
    wait_irq(60, r0);
    for (int k = 0; k < 3; k++) begin
      int_ack = 1;
      step(0);
      int_ack = 0;
      checks++;
      if (int_req !== 1'b0) begin
        failures++;
        $display("FAIL auto_ack%0d: int_req=%b, want 0", k, int_req);
      end
      wait_irq(40, r1);
      checks++;
      if (r0 < 0 || r1 < 0 || r1 - r0 != 16) begin
        failures++;
        $display("FAIL auto_period%0d: got %0d, want 16", k, (r0 < 0 || r1 < 0) ? -1 : r1 - r0);
      end
      r0 = r1;
    end
    wr_reg(REG_CTRL, 8'h00);
  endtask

  task automatic test_collisions();
    logic [7:0] rd;
    bit ok;
    int r0;
    wr_reg(REG_CTRL, 8'h00);
    wr_reg(REG_STATUS, 8'h01);
    wr_reg(REG_COUNT, 8'h00);
    wr_reg(REG_RELOAD, 8'h03);
    wr_reg(REG_CTRL, 8'h07);
    wait_irq(60, r0);
    if (r0 < 0) begin
      checks++;
      failures++;
      $display("FAIL collide_setup: no expiry seen, want one within 60 cycles");
      return;
    end
    // int_ack on the next expiry edge (r0+16)
    while (cyc_n < r0 + 15) step(0);
    int_ack = 1;
    step(0);
    int_ack = 0;
    checks++;
    if (int_req !== 1'b1) begin
      failures++;
      $display("FAIL collide_int_ack: int_req=%b, want 1", int_req);
    end
    // W1C to STATUS committing on the following expiry edge (r0+32)
    while (cyc_n < r0 + 31) step(0);
    wr_reg(REG_STATUS, 8'h01);
    checks++;
    if (int_req !== 1'b1) begin
      failures++;
      $display("FAIL collide_w1c: int_req=%b, want 1", int_req);
    end
    // COUNT write committing on the tick edge r0+36
    while (cyc_n < r0 + 35) step(0);
    wr_reg(REG_COUNT, 8'h09);
    rd_reg(REG_COUNT, rd, ok);
    checks++;
    if (rd !== 8'h09) begin
      failures++;
      $display("FAIL collide_count_write: got %h, want 09", rd);
    end
    wr_reg(REG_CTRL, 8'h00);
    wr_reg(REG_STATUS, 8'h01);
  endtask

  task automatic test_random();
    logic [7:0] rd, want, adr, d;
    logic [1:0] off;
    bit ok;
    int op;
    for (int n = 0; n < 200; n++) begin
      op = $urandom_range(0, 9);
      off = 2'($urandom_range(0, 3));
      if (op <= 3) begin
        d = $urandom;
        if (off == REG_COUNT) d = d & 8'h0F;
        if (off == REG_RELOAD) d = d & 8'h07;
        wr_reg(off, d);
      end else if (op <= 5) begin
        want = model_read(off);
        rd_reg(off, rd, ok);
        checks++;
        if (rd !== want || !ok) begin
          failures++;
          $display("FAIL rand_read%0d off=%0d: got %h ack_ok=%0d, want %h", n, off, rd, ok, want);
        end
      end else if (op == 6) begin
        adr = $urandom;
        if (adr[7:2] == BASE[7:2]) adr = adr ^ 8'h40;
        bus_xfer($urandom_range(0, 1), adr, $urandom, rd, ok);
        checks++;
        if (!ok || rd !== 8'h00) begin
          failures++;
          $display("FAIL rand_miss%0d adr=%h: dat=%h ack_ok=%0d, want 00 no ack", n, adr, rd, ok);
        end
      end else if (op == 7) begin
        int_ack = 1;
        step(0);
        int_ack = 0;
      end else begin
        repeat ($urandom_range(1, 12)) step(0);
      end
      checks++;
      if (int_req !== (m_exp & m_ie)) begin
        failures++;
        $display("FAIL rand_irq%0d: int_req=%b, want %b", n, int_req, m_exp & m_ie);
      end
    end
    wr_reg(REG_CTRL, 8'h00);
  endtask

`ifndef GUMNUT_PORT_TIMER_ZERO_WAIT_EN
  task automatic test_reset_mid_xfer();
    wr_reg(REG_RELOAD, 8'h5A);
    port_cyc = 1; port_stb = 1; port_we = 0; port_adr = BASE + 8'd1;
    step(1);
    #2 rst_i = 1;
    #1;
    model_reset();
    checks++;
    if (port_ack !== 1'b0 || port_dat_r !== 8'h00) begin
      failures++;
      $display("FAIL reset_mid_ack: ack=%b dat=%h, want 0/00", port_ack, port_dat_r);
    end
    @(negedge clk_i);
    rst_i = 0;
    step(1);
    checks++;
    if (port_ack !== 1'b1 || port_dat_r !== 8'h00) begin
      failures++;
      $display("FAIL reset_mid_fresh_ack: ack=%b dat=%h, want 1/00", port_ack, port_dat_r);
    end
    port_cyc = 0; port_stb = 0;
    step(0);
  endtask
`endif

  initial begin
    test_reset();
    test_readback();
    test_decode();
    test_stall();
    test_oneshot();
    test_autoreload();
    test_collisions();
    test_random();
`ifndef GUMNUT_PORT_TIMER_ZERO_WAIT_EN
    test_reset_mid_xfer();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
